hd_datapath: RTL and testbench

HD_DATAPATH -- requirements
Module: hd_datapath

---
 rtl/hd_pkg.sv | 31 +++
 rtl/hd_alu.sv | 45 ++++
 rtl/hd_datapath.sv | 183 ++++++++++++++++++
 tb/tb_hd_datapath.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hd_pkg.sv
// Shared constants for the hardwired-controller datapath: run state,
// one-hot beat encodings and ALU function codes.
package hd_pkg;

  typedef enum logic {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [3:1] BEAT_W1 = 3'b001;
  localparam logic [3:1] BEAT_W2 = 3'b010;
  localparam logic [3:1] BEAT_W3 = 3'b100;

  // Arithmetic codes (M=0)
  localparam logic [3:0] ALU_ADD  = 4'b1001;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_INCA = 4'b0000;

  // Logic codes (M=1); XOR shares its S pattern with SUB
  localparam logic [3:0] ALU_PASSB = 4'b1010;
  localparam logic [3:0] ALU_AND   = 4'b1011;
  localparam logic [3:0] ALU_XOR   = 4'b0110;
  localparam logic [3:0] ALU_OR    = 4'b1110;
  localparam logic [3:0] ALU_PASSA = 4'b1111;

  // Sign-extend a 4-bit branch offset to 8 bits
  function automatic logic [7:0] sext4(input logic [3:0] v);
    return {{4{v[3]}}, v};
  endfunction

endpackage

// File: rtl/hd_alu.sv
// Combinational 8-bit ALU. CIN is active-low; arithmetic results are
// 9 bits wide so COUT is bit 8. Unused codes yield zero with no carry.
module hd_alu
  import hd_pkg::*;
(
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] S,
  input  logic       M,
  input  logic       CIN,
  output logic [7:0] F,
  output logic       COUT
);

  logic       c;
  logic [8:0] res;

  assign c = ~CIN;

  // Function decode; logic ops never produce a carry
  always_comb begin
    res = 9'h000;
    if (!M) begin
      case (S)
        ALU_ADD:  res = {1'b0, A} + {1'b0, B} + {8'h00, c};
        ALU_SUB:  res = {1'b0, A} + {1'b0, ~B} + {8'h00, c};
        ALU_INCA: res = {1'b0, A} + {8'h00, c};
        default:  res = 9'h000;
      endcase
    end else begin
      case (S)
        ALU_PASSB: res = {1'b0, B};
        ALU_AND:   res = {1'b0, A & B};
        ALU_XOR:   res = {1'b0, A ^ B};
        ALU_OR:    res = {1'b0, A | B};
        ALU_PASSA: res = {1'b0, A};
        default:   res = 9'h000;
      endcase
    end
  end

  assign F    = res[7:0];
  assign COUT = res[8];

endmodule

// File: rtl/hd_datapath.sv
// Datapath for a hardwired-controller CPU: four 8-bit registers, ALU,
// PC/AR/IR, priority bus and a RUN/HALT beat sequencer.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_HALT | idle; all writes suppressed, W held; QD=1 starts running
// ST_RUN  | one beat per edge; W steps W1->W2(->W3)->W1; STOP halts
module hd_datapath
  import hd_pkg::*;
(
  input  logic       T3,
  input  logic       CLR,
  input  logic       LDC,
  input  logic       LDZ,
  input  logic       CIN,
  input  logic       M,
  input  logic       ABUS,
  input  logic       DRW,
  input  logic       PCINC,
  input  logic       LPC,
  input  logic       LAR,
  input  logic       PCADD,
  input  logic       ARINC,
  input  logic       SELCTL,
  input  logic       MEMW,
  input  logic       STOP,
  input  logic       LIR,
  input  logic       SBUS,
  input  logic       MBUS,
  input  logic       SHORT,
  input  logic       LONG,
  input  logic [3:0] S,
  input  logic [3:0] SEL,
  input  logic [7:0] SD,
  input  logic       QD,
  output logic [7:0] MEM_ADDR,
  output logic [7:0] MEM_WDATA,
  output logic       MEM_WE,
  input  logic [7:0] MEM_RDATA,
  output logic [7:4] IR,
  output logic       C,
  output logic       Z,
  output logic [3:1] W,
  output logic [7:0] PC,
  output logic [7:0] AR,
  output logic [7:0] BUS,
  output logic       HALTED,
  output logic       BUS_ERR
);

  state_t     state_r, state_nxt;
  logic [3:1] w_r, w_nxt;
  logic       run;
  logic       rf_we, c_we, z_we, ir_we, conflict;

  logic [7:0] rf [0:3];
  logic [7:0] pc_r, pc_nxt, ar_r, ar_nxt, ir_r;
  logic       c_r, z_r, berr_r;

  logic [1:0] rd_idx, b_idx;
  logic [7:0] a_v, b_v, f_v, bus_v;
  logic       cout_v;

  // Run state and beat register
  always_ff @(posedge T3) begin
    if (CLR) begin
      state_r <= ST_HALT;
      w_r     <= BEAT_W1;
    end else begin
      state_r <= state_nxt;
      w_r     <= w_nxt;
    end
  end

  // Next run state and beat
  always_comb begin
    state_nxt = state_r;
    w_nxt     = w_r;
    case (state_r)
      ST_HALT: begin
        if (QD) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        case (w_r)
          BEAT_W1: w_nxt = SHORT ? BEAT_W1 : BEAT_W2;
          BEAT_W2: w_nxt = LONG ? BEAT_W3 : BEAT_W1;
          default: w_nxt = BEAT_W1;
        endcase
        if (STOP) state_nxt = ST_HALT;
      end
      default: state_nxt = ST_HALT;
    endcase
  end

  // Write enables gated by RUN
  always_comb begin
    run      = (state_r == ST_RUN);
    rf_we    = run & DRW;
    c_we     = run & LDC;
    z_we     = run & LDZ;
    ir_we    = run & LIR;
    conflict = run & ((ABUS & MBUS) | (ABUS & SBUS) | (MBUS & SBUS));
  end

  // Register select: manual switches or instruction fields
  always_comb begin
    rd_idx = SELCTL ? SEL[3:2] : ir_r[3:2];
    b_idx  = SELCTL ? SEL[1:0] : ir_r[1:0];
    a_v    = rf[rd_idx];
    b_v    = rf[b_idx];
  end

  hd_alu u_alu (
    .A    (a_v),
    .B    (b_v),
    .S    (S),
    .M    (M),
    .CIN  (CIN),
    .F    (f_v),
    .COUT (cout_v)
  );

  // Bus source priority: ALU, then memory, then switches
  always_comb begin
    if (ABUS)      bus_v = f_v;
    else if (MBUS) bus_v = MEM_RDATA;
    else if (SBUS) bus_v = SD;
    else           bus_v = 8'h00;
  end

  // PC and AR next values from pre-edge sources
  always_comb begin
    pc_nxt = pc_r;
    if (LPC)        pc_nxt = bus_v;
    else if (PCADD) pc_nxt = pc_r + sext4(ir_r[3:0]);
    else if (PCINC) pc_nxt = pc_r + 8'h01;
    ar_nxt = ar_r;
    if (LAR)        ar_nxt = bus_v;
    else if (ARINC) ar_nxt = ar_r + 8'h01;
  end

  // Register file, flags and sticky bus-conflict flag
  always_ff @(posedge T3) begin
    if (CLR) begin
      for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
      c_r    <= 1'b0;
      z_r    <= 1'b0;
      berr_r <= 1'b0;
    end else begin
      if (rf_we)    rf[rd_idx] <= bus_v;
      if (c_we)     c_r        <= cout_v;
      if (z_we)     z_r        <= (f_v == 8'h00);
      if (conflict) berr_r     <= 1'b1;
    end
  end

  // Program counter, address register and instruction register
  always_ff @(posedge T3) begin
    if (CLR) begin
      pc_r <= 8'h00;
      ar_r <= 8'h00;
      ir_r <= 8'h00;
    end else if (run) begin
      pc_r <= pc_nxt;
      ar_r <= ar_nxt;
      if (ir_we) ir_r <= MEM_RDATA;
    end
  end

  assign MEM_ADDR  = LIR ? pc_r : ar_r;
  assign MEM_WDATA = bus_v;
  assign MEM_WE    = MEMW & run;
  assign IR        = ir_r[7:4];
  assign C         = c_r;
  assign Z         = z_r;
  assign W         = w_r;
  assign PC        = pc_r;
  assign AR        = ar_r;
  assign BUS       = bus_v;
  assign HALTED    = ~run;
  assign BUS_ERR   = berr_r;

endmodule

// File: tb/tb_hd_datapath.sv
// Scoreboard bench for hd_datapath: a driver applies one beat of controls
// per cycle and queues the expected response from a behavioural model;
// a monitor pops and compares each cycle.
module tb_hd_datapath;

  logic       T3 = 1'b0;
  logic       CLR, LDC, LDZ, CIN, M, ABUS, DRW, PCINC, LPC, LAR, PCADD, ARINC;
  logic       SELCTL, MEMW, STOP, LIR, SBUS, MBUS, SHORT, LONG, QD;
  logic [3:0] S, SEL;
  logic [7:0] SD, MEM_RDATA;
  logic [7:0] MEM_ADDR, MEM_WDATA, PC, AR, BUS;
  logic       MEM_WE, C, Z, HALTED, BUS_ERR;
  logic [7:4] IR;
  logic [3:1] W;

  always #5 T3 = ~T3;

  hd_datapath dut (
    .T3(T3), .CLR(CLR), .LDC(LDC), .LDZ(LDZ), .CIN(CIN), .M(M), .ABUS(ABUS),
    .DRW(DRW), .PCINC(PCINC), .LPC(LPC), .LAR(LAR), .PCADD(PCADD),
    .ARINC(ARINC), .SELCTL(SELCTL), .MEMW(MEMW), .STOP(STOP), .LIR(LIR),
    .SBUS(SBUS), .MBUS(MBUS), .SHORT(SHORT), .LONG(LONG), .S(S), .SEL(SEL),
    .SD(SD), .QD(QD), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_WE(MEM_WE), .MEM_RDATA(MEM_RDATA), .IR(IR), .C(C), .Z(Z), .W(W),
    .PC(PC), .AR(AR), .BUS(BUS), .HALTED(HALTED), .BUS_ERR(BUS_ERR)
  );

  typedef struct packed {
    logic clr, qd, ldc, ldz, cin, m, abus, drw, pcinc, lpc, lar, pcadd, arinc;
    logic selctl, memw, stop, lir, sbus, mbus, sh, lg;
    logic [3:0] s, sel;
    logic [7:0] sd, rdata;
  } ctl_t;

  typedef struct {
    bit         chk_comb;
    logic [7:0] bus, addr, wdata;
    logic       we;
    logic [7:0] w, pc, ar, irh;
    logic       c, z, halted, berr;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural model state
  bit m_known = 0;
  bit m_run   = 0;
  int m_beat  = 1;
  int m_pc = 0, m_ar = 0, m_ir = 0;
  int m_r[4];
  bit m_c = 0, m_z = 0, m_berr = 0;

  function automatic int alu_ref(int a, int b, int s, bit m, bit cin);
    int ci;
    ci = cin ? 0 : 1;
    if (!m) begin
      if (s == 9) return a + b + ci;
      if (s == 6) return a + (255 - b) + ci;
      if (s == 0) return a + ci;
      return 0;
    end
    case (s)
      10:      return b;
      11:      return a & b;
      6:       return a ^ b;
      14:      return a | b;
      15:      return a;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input ctl_t k);
    exp_t e;
    int   rd, bi, f, bus, off, nsrc;
    @(negedge T3);
    CLR = k.clr; QD = k.qd; LDC = k.ldc; LDZ = k.ldz; CIN = k.cin; M = k.m;
    ABUS = k.abus; DRW = k.drw; PCINC = k.pcinc; LPC = k.lpc; LAR = k.lar;
    PCADD = k.pcadd; ARINC = k.arinc; SELCTL = k.selctl; MEMW = k.memw;
    STOP = k.stop; LIR = k.lir; SBUS = k.sbus; MBUS = k.mbus; SHORT = k.sh;
    LONG = k.lg; S = k.s; SEL = k.sel; SD = k.sd; MEM_RDATA = k.rdata;

    rd  = k.selctl ? int'(k.sel[3:2]) : ((m_ir >> 2) & 3);
    bi  = k.selctl ? int'(k.sel[1:0]) : (m_ir & 3);
    f   = alu_ref(m_r[rd], m_r[bi], int'(k.s), k.m, k.cin);
    bus = k.abus ? (f % 256) : k.mbus ? int'(k.rdata) : k.sbus ? int'(k.sd) : 0;
    e.chk_comb = m_known;
    e.bus   = 8'(bus);
    e.wdata = 8'(bus);
    e.addr  = k.lir ? 8'(m_pc) : 8'(m_ar);
    e.we    = k.memw & m_run;

    if (k.clr) begin
      m_known = 1; m_run = 0; m_beat = 1;
      m_pc = 0; m_ar = 0; m_ir = 0;
      for (int i = 0; i < 4; i++) m_r[i] = 0;
      m_c = 0; m_z = 0; m_berr = 0;
    end else if (!m_run) begin
      if (k.qd) m_run = 1;
    end else begin
      nsrc = int'(k.abus) + int'(k.mbus) + int'(k.sbus);
      if (nsrc >= 2) m_berr = 1;
      if (k.ldc) m_c = (f >= 256);
      if (k.ldz) m_z = ((f % 256) == 0);
      if (k.drw) m_r[rd] = bus;
      off = ((m_ir & 15) >= 8) ? (m_ir & 15) - 16 : (m_ir & 15);
      if (k.lpc)        m_pc = bus;
      else if (k.pcadd) m_pc = (m_pc + off + 256) % 256;
      else if (k.pcinc) m_pc = (m_pc + 1) % 256;
      if (k.lar)        m_ar = bus;
      else if (k.arinc) m_ar = (m_ar + 1) % 256;
      if (k.lir) m_ir = int'(k.rdata);
      if (m_beat == 1)      m_beat = k.sh ? 1 : 2;
      else if (m_beat == 2) m_beat = k.lg ? 3 : 1;
      else                  m_beat = 1;
      if (k.stop) m_run = 0;
    end

    e.w      = 8'(1 << (m_beat - 1));
    e.pc     = 8'(m_pc);
    e.ar     = 8'(m_ar);
    e.irh    = 8'(m_ir >> 4);
    e.c      = m_c;
    e.z      = m_z;
    e.halted = !m_run;
    e.berr   = m_berr;
    q.push_back(e);
  endtask

  // Monitor: combinational outputs before the edge, registers after it
  initial begin
    exp_t e;
    forever begin
      @(negedge T3);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk_comb) begin
          chk("bus", BUS, e.bus);
          chk("mem_addr", MEM_ADDR, e.addr);
          chk("mem_wdata", MEM_WDATA, e.wdata);
          chk("mem_we", {7'b0, MEM_WE}, {7'b0, e.we});
        end
        @(posedge T3);
        #1;
        chk("w", {5'b0, W}, e.w);
        chk("pc", PC, e.pc);
        chk("ar", AR, e.ar);
        chk("ir_hi", {4'b0, IR}, e.irh);
        chk("c", {7'b0, C}, {7'b0, e.c});
        chk("z", {7'b0, Z}, {7'b0, e.z});
        chk("halted", {7'b0, HALTED}, {7'b0, e.halted});
        chk("bus_err", {7'b0, BUS_ERR}, {7'b0, e.berr});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic ctl_t rand_ctl();
    ctl_t k;
    int   r;
    int   codes[8] = '{9, 6, 0, 10, 11, 14, 15, 5};
    k = '0;
    k.clr    = ($urandom_range(0, 79) == 0);
    k.qd     = ($urandom_range(0, 2) == 0);
    k.stop   = ($urandom_range(0, 9) == 0);
    k.ldc    = 1'($urandom_range(0, 1));
    k.ldz    = 1'($urandom_range(0, 1));
    k.cin    = 1'($urandom_range(0, 1));
    k.m      = 1'($urandom_range(0, 1));
    k.drw    = 1'($urandom_range(0, 1));
    k.pcinc  = 1'($urandom_range(0, 1));
    k.lpc    = ($urandom_range(0, 3) == 0);
    k.lar    = ($urandom_range(0, 3) == 0);
    k.pcadd  = ($urandom_range(0, 2) == 0);
    k.arinc  = 1'($urandom_range(0, 1));
    k.selctl = 1'($urandom_range(0, 1));
    k.memw   = 1'($urandom_range(0, 1));
    k.lir    = ($urandom_range(0, 2) == 0);
    k.sh     = 1'($urandom_range(0, 1));
    k.lg     = 1'($urandom_range(0, 1));
    k.s      = 4'(codes[$urandom_range(0, 7)]);
    k.sel    = 4'($urandom_range(0, 15));
    k.sd     = 8'($urandom_range(0, 255));
    k.rdata  = 8'($urandom_range(0, 255));
    r = int'($urandom_range(0, 9));
    k.abus = (r == 1) || (r == 4) || (r == 7);
    k.mbus = (r == 2) || (r == 5) || (r == 7);
    k.sbus = (r == 3) || (r == 6) || (r == 8);
    return k;
  endfunction

  initial begin
    ctl_t k;
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    k = '0;
    CLR = 0; QD = 0; LDC = 0; LDZ = 0; CIN = 0; M = 0; ABUS = 0; DRW = 0;
    PCINC = 0; LPC = 0; LAR = 0; PCADD = 0; ARINC = 0; SELCTL = 0; MEMW = 0;
    STOP = 0; LIR = 0; SBUS = 0; MBUS = 0; SHORT = 0; LONG = 0;
    S = '0; SEL = '0; SD = '0; MEM_RDATA = '0;

    // Reset, then start
    k = '0; k.clr = 1; step(k);
    k = '0; step(k);
    k = '0; k.qd = 1; step(k);
    // Fetch at W1
    k = '0; k.lir = 1; k.pcinc = 1; k.rdata = 8'h14; step(k);
    // W2: R0 <= F0
    k = '0; k.sbus = 1; k.sd = 8'hF0; k.drw = 1; k.selctl = 1; k.sel = 4'b0000; step(k);
    // W1 with SHORT: R1 <= 20, stays W1
    k = '0; k.sh = 1; k.sbus = 1; k.sd = 8'h20; k.drw = 1; k.selctl = 1; k.sel = 4'b0100; step(k);
    // ADD R0,R1
    k = '0; k.s = 4'b1001; k.cin = 1; k.abus = 1; k.drw = 1; k.ldc = 1; k.ldz = 1;
    k.selctl = 1; k.sel = 4'b0001; step(k);
    // W2 with LONG: R1 <= 55 ; W3: R0 <= 55
    k = '0; k.lg = 1; k.sbus = 1; k.sd = 8'h55; k.drw = 1; k.selctl = 1; k.sel = 4'b0100; step(k);
    k = '0; k.sbus = 1; k.sd = 8'h55; k.drw = 1; k.selctl = 1; k.sel = 4'b0000; step(k);
    // SUB R0,R1
    k = '0; k.s = 4'b0110; k.cin = 0; k.abus = 1; k.drw = 1; k.ldc = 1; k.ldz = 1;
    k.selctl = 1; k.sel = 4'b0001; step(k);
    // STOP at W2
    k = '0; k.stop = 1; step(k);
    // Halted: nothing may change
    k = '0; k.sbus = 1; k.sd = 8'hA5; k.drw = 1; k.lpc = 1; k.lar = 1; k.memw = 1;
    k.lir = 1; k.ldc = 1; k.ldz = 1; k.selctl = 1; k.rdata = 8'h77; step(k);
    k.abus = 1; step(k);
    k = '0; k.qd = 1; step(k);
    // PC=05, IR=3E, then PCADD; AR=FF, then ARINC
    k = '0; k.sh = 1; k.lpc = 1; k.sbus = 1; k.sd = 8'h05; k.lir = 1; k.rdata = 8'h3E; step(k);
    k = '0; k.sh = 1; k.pcadd = 1; step(k);
    k = '0; k.sh = 1; k.lar = 1; k.sbus = 1; k.sd = 8'hFF; step(k);
    k = '0; k.sh = 1; k.arinc = 1; step(k);
    // Bus conflict: ABUS wins, BUS_ERR sticks until CLR
    k = '0; k.abus = 1; k.sbus = 1; k.m = 1; k.s = 4'b1010; k.selctl = 1;
    k.sel = 4'b0001; k.sd = 8'hAA; step(k);
    k = '0; step(k);
    k = '0; step(k);
    k = '0; k.clr = 1; step(k);
    k = '0; step(k);

    // Randomized phase
    for (int n = 0; n < 3000; n++) step(rand_ctl());

    repeat (3) @(negedge T3);
    #4;
    chk("queue_drained", 8'(q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
